// File: rtl/event_tagger_multi.sv
// Event tagger: time-stamps strobe pulses, delta-channel level changes and timer wrap markers into a record FIFO.
// Optional macro EVENT_TAGGER_INPUT_SYNC_EN adds two-flop input synchronizers ahead of event detection.
`timescale 1ns/1ps
module event_tagger_multi #(
  parameter int STROBE_CH  = 4,
  parameter int DELTA_CH   = 4,
  parameter int TIMER_W    = 36,
  parameter int FIFO_DEPTH = 16,
  parameter int LOST_W     = 16,
  localparam int CH_W      = (STROBE_CH > DELTA_CH) ? STROBE_CH : DELTA_CH,
  localparam int REC_W     = TIMER_W + CH_W + 3,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [STROBE_CH-1:0] strobe_channels,
  input  logic [DELTA_CH-1:0]  delta_channels,
  input  logic [STROBE_CH-1:0] strobe_mask,
  input  logic                 capture_operate,
  input  logic                 counter_operate,
  input  logic                 clear_timer,
  output logic [REC_W-1:0]     data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic [LOST_W-1:0]    lost_count,
  output logic [LVL_W-1:0]     fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Input sampling
  // ---------------------------------------------------------------------------
  logic [STROBE_CH-1:0] s_in;
  logic [DELTA_CH-1:0]  d_in;

`ifdef EVENT_TAGGER_INPUT_SYNC_EN
  logic [STROBE_CH-1:0] s_meta, s_sync;
  logic [DELTA_CH-1:0]  d_meta, d_sync;

  // Left out of reset so old_delta can capture the settled level during reset.
  always_ff @(posedge clk) begin
    s_meta <= strobe_channels;
    s_sync <= s_meta;
    d_meta <= delta_channels;
    d_sync <= d_meta;
  end

  assign s_in = s_sync;
  assign d_in = d_sync;
`else
  assign s_in = strobe_channels;
  assign d_in = delta_channels;
`endif

  // ---------------------------------------------------------------------------
  // Free-running timer
  // ---------------------------------------------------------------------------
  logic [TIMER_W-1:0] timer;

  always_ff @(posedge clk) begin
    if (!reset_n)         timer <= '0;
    else if (clear_timer) timer <= '0;
    else                  timer <= timer + TIMER_W'(counter_operate);
  end

  // ---------------------------------------------------------------------------
  // Record generation with a one-deep pending strobe slot
  // ---------------------------------------------------------------------------
  logic [DELTA_CH-1:0] old_delta;
  logic                slot_valid, slot_valid_nx;
  logic [CH_W-1:0]     slot_ch, slot_ch_nx;
  logic [TIMER_W-1:0]  slot_ts, slot_ts_nx;
  logic                slot_wrap, slot_wrap_nx;

  logic [CH_W-1:0]     s_ext, d_ext;
  logic                wrap_now, delta_evt, strobe_evt;

  logic                gen_fire;
  logic                rec_type, rec_wrap;
  logic [CH_W-1:0]     rec_ch;
  logic [TIMER_W-1:0]  rec_ts;

  // Generated record without the lost bit; that bit is only known at FIFO write.
  logic                gen_valid;
  logic [REC_W-2:0]    gen_body;

  assign s_ext      = CH_W'(s_in & strobe_mask);
  assign d_ext      = CH_W'(d_in);
  assign wrap_now   = counter_operate && (timer == '0);
  assign delta_evt  = (d_in != old_delta);
  assign strobe_evt = (s_ext != '0) || wrap_now;

  always_comb begin
    gen_fire      = 1'b0;
    rec_type      = 1'b0;
    rec_wrap      = 1'b0;
    rec_ch        = '0;
    rec_ts        = timer;
    slot_valid_nx = slot_valid;
    slot_ch_nx    = slot_ch;
    slot_ts_nx    = slot_ts;
    slot_wrap_nx  = slot_wrap;

    if (delta_evt) begin
      // Delta wins; concurrent strobes park in the slot (a wrap rides on the delta record).
      gen_fire = 1'b1;
      rec_type = 1'b1;
      rec_wrap = wrap_now;
      rec_ch   = d_ext;
      if (s_ext != '0) begin
        if (slot_valid) begin
          slot_ch_nx = slot_ch | s_ext;
        end else begin
          slot_valid_nx = 1'b1;
          slot_ch_nx    = s_ext;
          slot_ts_nx    = timer;
          slot_wrap_nx  = wrap_now;
        end
      end
    end else if (slot_valid) begin
      gen_fire      = 1'b1;
      rec_wrap      = slot_wrap;
      rec_ch        = slot_ch;
      rec_ts        = slot_ts;
      slot_valid_nx = strobe_evt;
      slot_ch_nx    = s_ext;
      slot_ts_nx    = timer;
      slot_wrap_nx  = wrap_now;
    end else if (strobe_evt) begin
      gen_fire = 1'b1;
      rec_wrap = wrap_now;
      rec_ch   = s_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      old_delta  <= d_in;
      slot_valid <= 1'b0;
      slot_ch    <= '0;
      slot_ts    <= '0;
      slot_wrap  <= 1'b0;
      gen_valid  <= 1'b0;
      gen_body   <= '0;
    end else begin
      old_delta  <= d_in;
      slot_valid <= slot_valid_nx;
      slot_ch    <= slot_ch_nx;
      slot_ts    <= slot_ts_nx;
      slot_wrap  <= slot_wrap_nx;
      gen_valid  <= gen_fire && capture_operate;
      gen_body   <= {rec_wrap, rec_type, rec_ch, rec_ts};
    end
  end

  // ---------------------------------------------------------------------------
  // Record FIFO: memory plus a registered show-ahead head slot.
  // Handshake: data/data_valid are registers; a record transfers on a rising
  // clk edge where data_valid && data_ready, and data is held unchanged while
  // data_valid is high and data_ready is low. Occupancy counts the head slot.
  // ---------------------------------------------------------------------------
  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      mem_count;
  logic [AW:0]      level;
  logic [REC_W-1:0] data_q;
  logic             data_valid_q;
  logic             lost_flag;
  logic [LOST_W-1:0] lost_q;

  logic             pop, full, wr_ok, wr_drop, load;
  logic [REC_W-1:0] wr_rec;

  assign level   = mem_count + (AW+1)'(data_valid_q);
  assign pop     = data_valid_q && data_ready;
  // A consumer pop in the same cycle frees a place for the incoming record.
  assign full    = (level == (AW+1)'(FIFO_DEPTH)) && !pop;
  assign wr_ok   = gen_valid && !full;
  assign wr_drop = gen_valid && full;
  assign load    = (mem_count != '0) && (!data_valid_q || data_ready);
  assign wr_rec  = {lost_flag, gen_body};

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_rec;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      mem_count    <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      lost_flag    <= 1'b0;
      lost_q       <= '0;
    end else begin
      mem_count <= mem_count + (AW+1)'(wr_ok) - (AW+1)'(load);
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (load) begin
        data_q       <= mem[rd_ptr];
        data_valid_q <= 1'b1;
        rd_ptr       <= rd_ptr + AW'(1);
      end else if (pop) begin
        data_valid_q <= 1'b0;
      end
      if (wr_drop) begin
        lost_flag <= 1'b1;
        if (lost_q != '1) lost_q <= lost_q + LOST_W'(1);
      end else if (wr_ok && lost_flag) begin
        lost_flag <= 1'b0;
      end
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign lost_count = lost_q;
  assign fifo_level = level;

endmodule

// File: tb/tb_event_tagger_multi.sv
// Directed bench for event_tagger_multi (TIMER_W = 8, FIFO_DEPTH = 4) with hand-computed records.
`timescale 1ns/1ps
module tb_event_tagger_multi;

  localparam int SC    = 4;
  localparam int DC    = 4;
  localparam int TW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = 16;
  localparam int REC_W = TW + 4 + 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [SC-1:0]     strobe_channels;
  logic [DC-1:0]     delta_channels;
  logic [SC-1:0]     strobe_mask;
  logic              capture_operate;
  logic              counter_operate;
  logic              clear_timer;
  logic [REC_W-1:0]  data;
  logic              data_valid;
  logic              data_ready;
  logic [LW-1:0]     lost_count;
  logic [2:0]        fifo_level;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int seen_cyc = 0;
  logic [REC_W-1:0] exp_q[$];

  event_tagger_multi #(
    .STROBE_CH(SC), .DELTA_CH(DC), .TIMER_W(TW), .FIFO_DEPTH(DEPTH), .LOST_W(LW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .strobe_channels(strobe_channels), .delta_channels(delta_channels),
    .strobe_mask(strobe_mask), .capture_operate(capture_operate),
    .counter_operate(counter_operate), .clear_timer(clear_timer),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .lost_count(lost_count), .fifo_level(fifo_level)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] mk(input logic lost, input logic wrap, input logic typ,
                                          input logic [3:0] ch, input logic [7:0] ts);
    return {lost, wrap, typ, ch, ts};
  endfunction

  // Freeze the timer at v without generating any captured record.
  task automatic set_timer(input int v);
    counter_operate = 1'b0;
    capture_operate = 1'b0;
    clear_timer = 1'b1;
    tick();
    clear_timer = 1'b0;
    counter_operate = 1'b1;
    repeat (v) tick();
    counter_operate = 1'b0;
    capture_operate = 1'b1;
  endtask

  // Wait (bounded) for the head record, compare with the scoreboard front, consume it.
  task automatic pop_one(input string tag, input int budget);
    int n;
    logic [REC_W-1:0] e;
    n = 0;
    e = exp_q.pop_front();
    while (!data_valid && n < budget) begin
      tick();
      n++;
    end
    if (!data_valid) begin
      check({tag, "_timeout"}, 64'(data_valid), 64'd1);
    end else begin
      seen_cyc = cyc;
      check(tag, 64'(data), 64'(e));
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) pop_one(tag, 20);
  endtask

  initial begin
    int c1, got, first_c, last_c;
    reset_n = 1'b0;
    strobe_channels = '0;
    delta_channels = '0;
    strobe_mask = 4'b1111;
    capture_operate = 1'b1;
    counter_operate = 1'b0;
    clear_timer = 1'b0;
    data_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", 64'(data_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_lost", 64'(lost_count), 64'd0);
    check("rst_data", 64'(data), 64'd0);
    reset_n = 1'b1;
    repeat (3) tick();
    check("release_level", 64'(fifo_level), 64'd0);

    // Latency and hold-while-stalled
    set_timer(10);
    strobe_channels = 4'b0101;
    tick();
    strobe_channels = '0;
    check("lat_e0_valid", 64'(data_valid), 64'd0);
    tick();
    check("lat_e1_valid", 64'(data_valid), 64'd0);
    check("lat_e1_level", 64'(fifo_level), 64'd1);
    tick();
    check("lat_e2_valid", 64'(data_valid), 64'd1);
    check("lat_e2_data", 64'(data), 64'(mk(0, 0, 0, 4'b0101, 8'd10)));
    tick();
    check("hold_valid", 64'(data_valid), 64'd1);
    check("hold_data", 64'(data), 64'(mk(0, 0, 0, 4'b0101, 8'd10)));
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("consumed_valid", 64'(data_valid), 64'd0);
    check("consumed_level", 64'(fifo_level), 64'd0);

    // Delta and strobe in the same cycle: delta first, strobe from the slot
    set_timer(20);
    delta_channels = 4'b0011;
    strobe_channels = 4'b0001;
    tick();
    strobe_channels = '0;
    tick();
    exp_q.push_back(mk(0, 0, 1, 4'b0011, 8'd20));
    exp_q.push_back(mk(0, 0, 0, 4'b0001, 8'd20));
    drain("delta_then_strobe");

    // Slot drains before a fresh strobe, which refills it with its own timestamp
    set_timer(30);
    counter_operate = 1'b1;
    delta_channels = 4'b0111;
    strobe_channels = 4'b0010;
    tick();
    strobe_channels = 4'b0100;
    tick();
    strobe_channels = '0;
    tick();
    counter_operate = 1'b0;
    exp_q.push_back(mk(0, 0, 1, 4'b0111, 8'd30));
    exp_q.push_back(mk(0, 0, 0, 4'b0010, 8'd30));
    exp_q.push_back(mk(0, 0, 0, 4'b0100, 8'd31));
    drain("slot_refill");

    // Strobes during back-to-back deltas merge into the slot, keeping its timestamp
    set_timer(60);
    counter_operate = 1'b1;
    delta_channels = 4'b0110;
    strobe_channels = 4'b0001;
    tick();
    delta_channels = 4'b1110;
    strobe_channels = 4'b0100;
    tick();
    strobe_channels = '0;
    tick();
    counter_operate = 1'b0;
    exp_q.push_back(mk(0, 0, 1, 4'b0110, 8'd60));
    exp_q.push_back(mk(0, 0, 1, 4'b1110, 8'd61));
    exp_q.push_back(mk(0, 0, 0, 4'b0101, 8'd60));
    drain("slot_or");

    // Wrap markers: one right after clear, then one every 256 cycles
    counter_operate = 1'b1;
    clear_timer = 1'b1;
    tick();
    clear_timer = 1'b0;
    exp_q.push_back(mk(0, 1, 0, 4'b0000, 8'd0));
    pop_one("wrap_after_clear", 10);
    c1 = seen_cyc;
    exp_q.push_back(mk(0, 1, 0, 4'b0000, 8'd0));
    pop_one("wrap_next", 300);
    check("wrap_period", 64'(seen_cyc - c1), 64'd256);
    counter_operate = 1'b0;

    // Overflow: 6 records into 4 places
    set_timer(40);
    strobe_channels = 4'b0001;
    repeat (6) tick();
    strobe_channels = '0;
    repeat (3) tick();
    check("ovf_level", 64'(fifo_level), 64'd4);
    check("ovf_lost", 64'(lost_count), 64'd2);
    check("ovf_valid", 64'(data_valid), 64'd1);
    repeat (4) exp_q.push_back(mk(0, 0, 0, 4'b0001, 8'd40));
    drain("ovf_kept");
    strobe_channels = 4'b0010;
    tick();
    strobe_channels = 4'b0100;
    tick();
    strobe_channels = '0;
    exp_q.push_back(mk(1, 0, 0, 4'b0010, 8'd40));
    exp_q.push_back(mk(0, 0, 0, 4'b0100, 8'd40));
    drain("lost_marking");
    check("lost_after", 64'(lost_count), 64'd2);

    // Masked strobe and capture disabled produce nothing
    strobe_mask = 4'b1110;
    strobe_channels = 4'b0001;
    tick();
    strobe_channels = '0;
    repeat (4) tick();
    check("mask_level", 64'(fifo_level), 64'd0);
    check("mask_valid", 64'(data_valid), 64'd0);
    capture_operate = 1'b0;
    strobe_channels = 4'b0010;
    tick();
    strobe_channels = '0;
    capture_operate = 1'b1;
    repeat (4) tick();
    check("nocap_level", 64'(fifo_level), 64'd0);
    check("nocap_lost", 64'(lost_count), 64'd2);
    strobe_mask = 4'b1111;

    // Sustained one-in one-out with the consumer always ready
    set_timer(50);
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(0, 0, 0, 4'b1000, 8'(50 + i)));
    data_ready = 1'b1;
    counter_operate = 1'b1;
    got = 0;
    first_c = 0;
    last_c = 0;
    for (int i = 0; i < 14; i++) begin
      strobe_channels = (i < 6) ? 4'b1000 : 4'b0000;
      tick();
      if (data_valid) begin
        if (exp_q.size() > 0) begin
          check("stream", 64'(data), 64'(exp_q.pop_front()));
          if (got == 0) first_c = cyc;
          last_c = cyc;
          got++;
        end else begin
          check("stream_extra", 64'(data_valid), 64'd0);
        end
      end
    end
    data_ready = 1'b0;
    counter_operate = 1'b0;
    exp_q.delete();
    check("stream_count", 64'(got), 64'd6);
    check("stream_gap", 64'(last_c - first_c), 64'd5);
    check("stream_lost", 64'(lost_count), 64'd2);

    // Reset in the middle of a full, overflowing burst
    set_timer(70);
    strobe_channels = 4'b0001;
    repeat (3) tick();
    strobe_channels = '0;
    repeat (3) tick();
    check("pre_rst_level3", 64'(fifo_level), 64'd3);
    strobe_channels = 4'b0001;
    repeat (2) tick();
    strobe_channels = '0;
    repeat (3) tick();
    check("pre_rst_level4", 64'(fifo_level), 64'd4);
    check("pre_rst_lost", 64'(lost_count), 64'd3);
    reset_n = 1'b0;
    delta_channels = 4'b0101;
    tick();
    check("mid_rst_valid", 64'(data_valid), 64'd0);
    check("mid_rst_level", 64'(fifo_level), 64'd0);
    check("mid_rst_lost", 64'(lost_count), 64'd0);
    reset_n = 1'b1;
    repeat (4) tick();
    check("post_rst_level", 64'(fifo_level), 64'd0);
    check("post_rst_valid", 64'(data_valid), 64'd0);
    strobe_channels = 4'b0010;
    tick();
    strobe_channels = '0;
    exp_q.push_back(mk(0, 0, 0, 4'b0010, 8'd0));
    drain("post_rst_timer");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
